// File: rtl/lag_window_fsm.sv
// Lag-window stage of the G.729 LPC chain: scales r[1..M] in scratch memory by the fixed lag window.
// Define LAGWIN_COPY_EN to write results (and an unchanged copy of r[0]) to OUT_BASE instead of in place.
module lag_window_fsm #(
  parameter int          M      = 10,
  parameter logic [10:0] R_BASE = 11'h100
`ifdef LAGWIN_COPY_EN
  , parameter logic [10:0] OUT_BASE = 11'h180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [31:0] memIn,
  output logic [10:0] readRequested,
  output logic [10:0] writeRequested,
  output logic [31:0] memOut,
  output logic        writeEn,
  output logic        done
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD   = 4'd1;
  localparam logic [3:0] S_RDW  = 4'd2;
  localparam logic [3:0] S_CALC = 4'd3;
  localparam logic [3:0] S_WR   = 4'd4;
  localparam logic [3:0] S_DN   = 4'd5;
`ifdef LAGWIN_COPY_EN
  localparam logic [3:0] S_RD0  = 4'd6;
  localparam logic [3:0] S_RDW0 = 4'd7;
  localparam logic [3:0] S_WR0  = 4'd8;
  localparam logic [10:0] DST_BASE = OUT_BASE;
`else
  localparam logic [10:0] DST_BASE = R_BASE;
`endif

  localparam logic [3:0]         LAST  = 4'(M);
  localparam logic signed [33:0] MAX32 = 34'h0_7FFF_FFFF;
  localparam logic signed [33:0] MIN32 = 34'h3_8000_0000;

  logic [3:0]  state, state_n;
  logic [3:0]  i, i_n;
  logic [15:0] r_h, r_l;
  // Only L[31:1] survives L_Extract, so bit 0 is never stored.
  logic [30:0] prod_q;
  logic [15:0] lag_h, lag_l;
  logic [31:0] mpy_l;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
    if (x > MAX32) return 32'sh7FFF_FFFF;
    if (x < MIN32) return 32'sh8000_0000;
    return x[31:0];
  endfunction

  function automatic logic signed [15:0] mult(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] pa, pb, p;
    pa = {{16{a[15]}}, a};
    pb = {{16{b[15]}}, b};
    p  = (pa * pb) >>> 15;
    // Only -32768 * -32768 can exceed the 16-bit range.
    if (p > 32'sd32767) return 16'sh7FFF;
    return p[15:0];
  endfunction

  function automatic logic signed [31:0] mpy32(input logic signed [15:0] h1,
                                               input logic signed [15:0] l1,
                                               input logic signed [15:0] h2,
                                               input logic signed [15:0] l2);
    logic signed [33:0] x, y, t, acc;
    logic signed [31:0] s;
    logic signed [15:0] m;
    x   = {{18{h1[15]}}, h1};
    y   = {{18{h2[15]}}, h2};
    s   = sat32((x * y) <<< 1);
    acc = {{2{s[31]}}, s};
    m   = mult(h1, l2);
    t   = {{18{m[15]}}, m};
    s   = sat32(acc + (t <<< 1));
    acc = {{2{s[31]}}, s};
    m   = mult(l1, h2);
    t   = {{18{m[15]}}, m};
    return sat32(acc + (t <<< 1));
  endfunction

  // Lag window ROM, indexed by the 1-based coefficient number.
  always_comb begin
    lag_h = 16'd0;
    lag_l = 16'd0;
    case (i)
      4'd1:  begin lag_h = 16'd32728; lag_l = 16'd11904; end
      4'd2:  begin lag_h = 16'd32619; lag_l = 16'd17280; end
      4'd3:  begin lag_h = 16'd32438; lag_l = 16'd30720; end
      4'd4:  begin lag_h = 16'd32187; lag_l = 16'd25856; end
      4'd5:  begin lag_h = 16'd31867; lag_l = 16'd24192; end
      4'd6:  begin lag_h = 16'd31480; lag_l = 16'd28992; end
      4'd7:  begin lag_h = 16'd31029; lag_l = 16'd24384; end
      4'd8:  begin lag_h = 16'd30517; lag_l = 16'd7360;  end
      4'd9:  begin lag_h = 16'd29946; lag_l = 16'd19520; end
      4'd10: begin lag_h = 16'd29321; lag_l = 16'd14784; end
      default: begin lag_h = 16'd0; lag_l = 16'd0; end
    endcase
  end

  assign mpy_l = mpy32(r_h, r_l, lag_h, lag_l);

  always_comb begin
    state_n = state;
    i_n     = i;
    case (state)
      S_IDLE: begin
        if (ready) begin
          i_n = 4'd1;
`ifdef LAGWIN_COPY_EN
          state_n = S_RD0;
`else
          state_n = S_RD;
`endif
        end
      end
      S_RD:   state_n = S_RDW;
      S_RDW:  state_n = S_CALC;
      S_CALC: state_n = S_WR;
      S_WR: begin
        if (i == LAST) begin
          state_n = S_DN;
        end else begin
          i_n     = i + 4'd1;
          state_n = S_RD;
        end
      end
      S_DN:   state_n = S_IDLE;
`ifdef LAGWIN_COPY_EN
      S_RD0:  state_n = S_RDW0;
      S_RDW0: state_n = S_WR0;
      S_WR0:  state_n = S_RD;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      i      <= 4'd1;
      r_h    <= 16'd0;
      r_l    <= 16'd0;
      prod_q <= 31'd0;
    end else begin
      state <= state_n;
      i     <= i_n;
`ifdef LAGWIN_COPY_EN
      if (state == S_RDW || state == S_RDW0) begin
`else
      if (state == S_RDW) begin
`endif
        r_h <= memIn[31:16];
        r_l <= memIn[15:0];
      end
      if (state == S_CALC) prod_q <= mpy_l[31:1];
    end
  end

  // Outputs decode straight from state, so reset silences them on the same edge.
  always_comb begin
    readRequested  = 11'd0;
    writeRequested = 11'd0;
    memOut         = 32'd0;
    writeEn        = 1'b0;
    done           = 1'b0;
    case (state)
      S_RD, S_RDW: readRequested = R_BASE + {7'd0, i};
      S_WR: begin
        writeRequested = DST_BASE + {7'd0, i};
        memOut         = {prod_q[30:15], 1'b0, prod_q[14:0]};
        writeEn        = 1'b1;
      end
      S_DN: done = 1'b1;
`ifdef LAGWIN_COPY_EN
      S_RD0, S_RDW0: readRequested = R_BASE;
      S_WR0: begin
        writeRequested = OUT_BASE;
        memOut         = {r_h, r_l};
        writeEn        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
